// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// RISC-V opcode constants, instruction width and immediate decoders used by
// the optional static branch predictor (enabled with BRANCH_PREDICT_EN).
// Queue entry layout, MSB to LSB: {predTaken, pc, instr}.
package instruction_fetch_pkg;

   localparam int INSTR_W = 32;

   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } fetch_state_t;

   // J-type immediate, sign-extended to 32 bits
   function automatic logic signed [31:0] j_imm(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   // B-type immediate, sign-extended to 32 bits
   function automatic logic signed [31:0] b_imm(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Circular FIFO holding fetched instruction entries between the ICache and
// the decoder. Head/tail pointers wrap naturally; the count is one bit wider
// so that full and empty are distinguishable. Clear is synchronous and wins
// over any same-cycle enqueue or dequeue. Storage itself is not reset; the
// head output is forced to zero whenever the queue is empty.
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DATA_W      = 1 + 17 + INSTR_W,
   parameter int QUEUE_WIDTH = 3
) (
   input  logic                   clkIn,
   input  logic                   resetIn,
   input  logic                   clearIn,
   input  logic                   enqIn,
   input  logic [DATA_W-1:0]      enqData,
   input  logic                   deqIn,
   output logic                   validOut,
   output logic [DATA_W-1:0]      headData,
   output logic [QUEUE_WIDTH:0]   countOut
);

   localparam int DEPTH = 2 ** QUEUE_WIDTH;

   logic [DATA_W-1:0]      r_mem [DEPTH];
   logic [QUEUE_WIDTH-1:0] r_head;
   logic [QUEUE_WIDTH-1:0] r_tail;
   logic [QUEUE_WIDTH:0]   r_count;
   logic                   w_deq;
   logic                   w_empty;

   assign w_empty  = (r_count == '0);
   assign w_deq    = deqIn && !w_empty;
   assign validOut = !w_empty;
   assign headData = w_empty ? '0 : r_mem[r_head];
   assign countOut = r_count;

   // Entry storage: written at the tail on enqueue, no reset needed
   always_ff @(posedge clkIn) begin
      if (enqIn) begin
         r_mem[r_tail] <= enqData;
      end
   end

   // Pointer and occupancy bookkeeping; clear empties the queue
   always_ff @(posedge clkIn) begin
      if (resetIn || clearIn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (enqIn) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_deq) begin
            r_head <= r_head + 1'b1;
         end
         r_count <= r_count + {{QUEUE_WIDTH{1'b0}}, enqIn} - {{QUEUE_WIDTH{1'b0}}, w_deq};
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, issues one ICache request at a time,
// buffers responses in fetch_queue and presents them in order to the decoder.
// A flush redirects the PC and empties the queue; a request already in flight
// cannot be cancelled, so its response is discarded when it arrives.
// Optional feature macro: BRANCH_PREDICT_EN (static prediction of JAL and
// backward conditional branches). Without it the PC always advances by 4
// and predTakenOut is always 0.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH  = 17,
   parameter int QUEUE_WIDTH = 3,
   parameter int RESET_PC    = 0
) (
   input  logic                  clkIn,
   input  logic                  resetIn,
   input  logic                  cacheInstrValid,
   input  logic [INSTR_W-1:0]    cacheInstr,
   output logic                  fetchValid,
   output logic [ADDR_WIDTH-1:0] fetchAddr,
   input  logic                  flushIn,
   input  logic [ADDR_WIDTH-1:0] flushPcIn,
   input  logic                  instrReady,
   output logic                  instrValid,
   output logic [INSTR_W-1:0]    instrOut,
   output logic [ADDR_WIDTH-1:0] instrPcOut,
   output logic                  predTakenOut
);

   localparam int                   ENTRY_W    = 1 + ADDR_WIDTH + INSTR_W;
   localparam logic [QUEUE_WIDTH:0] DEPTH_CNT  = (QUEUE_WIDTH + 1)'(2 ** QUEUE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

   fetch_state_t           r_state;
   logic [ADDR_WIDTH-1:0]  r_pc;
   logic                   r_discard;
   logic                   r_fetchValid;
   logic [ADDR_WIDTH-1:0]  r_fetchAddr;

   logic                   w_enq;
   logic                   w_deq;
   logic [ENTRY_W-1:0]     w_enqData;
   logic [ENTRY_W-1:0]     w_headData;
   logic [QUEUE_WIDTH:0]   w_count;
   logic                   w_qValid;
   logic [ADDR_WIDTH-1:0]  w_pcInc;
   logic [ADDR_WIDTH-1:0]  w_nextPc;
   logic                   w_predTaken;

   assign w_pcInc = r_pc + ADDR_WIDTH'(4);

`ifdef BRANCH_PREDICT_EN
   logic signed [31:0] w_jImm;
   logic signed [31:0] w_bImm;
   logic [31:0]        w_jSum;
   logic [31:0]        w_bSum;

   assign w_jImm = j_imm(cacheInstr);
   assign w_bImm = b_imm(cacheInstr);
   assign w_jSum = 32'(r_pc) + w_jImm;
   assign w_bSum = 32'(r_pc) + w_bImm;

   // Static prediction: JAL always taken, backward conditional branch taken
   always_comb begin
      w_nextPc    = w_pcInc;
      w_predTaken = 1'b0;
      if (cacheInstr[6:0] == OPCODE_JAL) begin
         w_nextPc    = {w_jSum[ADDR_WIDTH-1:2], 2'b00};
         w_predTaken = 1'b1;
      end else if (cacheInstr[6:0] == OPCODE_BRANCH && w_bImm[31]) begin
         w_nextPc    = {w_bSum[ADDR_WIDTH-1:2], 2'b00};
         w_predTaken = 1'b1;
      end
   end
`else
   assign w_nextPc    = w_pcInc;
   assign w_predTaken = 1'b0;
`endif

   // A response is kept only if it is not stale and no flush lands this cycle
   assign w_enq     = (r_state == ST_WAIT) && cacheInstrValid && !r_discard && !flushIn;
   assign w_deq     = w_qValid && instrReady && !flushIn;
   assign w_enqData = {w_predTaken, r_pc, cacheInstr};

   fetch_queue #(
      .DATA_W      (ENTRY_W),
      .QUEUE_WIDTH (QUEUE_WIDTH)
   ) u_queue (
      .clkIn    (clkIn),
      .resetIn  (resetIn),
      .clearIn  (flushIn),
      .enqIn    (w_enq),
      .enqData  (w_enqData),
      .deqIn    (w_deq),
      .validOut (w_qValid),
      .headData (w_headData),
      .countOut (w_count)
   );

   // Request FSM with PC, discard flag and registered ICache request outputs
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC_A;
         r_discard    <= 1'b0;
         r_fetchValid <= 1'b0;
         r_fetchAddr  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flushIn) begin
                  r_pc <= flushPcIn;
               end else if (w_count < DEPTH_CNT) begin
                  r_state      <= ST_WAIT;
                  r_fetchValid <= 1'b1;
                  r_fetchAddr  <= r_pc;
               end
            end
            ST_WAIT: begin
               if (cacheInstrValid) begin
                  // Any response retires the outstanding request, stale or not
                  r_state      <= ST_IDLE;
                  r_fetchValid <= 1'b0;
                  r_discard    <= 1'b0;
                  if (flushIn) begin
                     r_pc <= flushPcIn;
                  end else if (!r_discard) begin
                     r_pc <= w_nextPc;
                  end
               end else if (flushIn) begin
                  r_discard <= 1'b1;
                  r_pc      <= flushPcIn;
               end
            end
         endcase
      end
   end

   assign fetchValid   = r_fetchValid;
   assign fetchAddr    = r_fetchAddr;
   assign instrValid   = w_qValid;
   assign instrOut     = w_headData[INSTR_W-1:0];
   assign instrPcOut   = w_headData[INSTR_W +: ADDR_WIDTH];
   assign predTakenOut = w_headData[ENTRY_W-1];

endmodule
